ghost_mover: RTL and testbench
==============================

# ghost_mover

Parametrised ghost movement controller for the Pacman playfield: holds one ghost's position and heading and advances it one step per `move_tick` strobe, choosing a new heading at walls and junctions according to a selectable mode (random wander, chase player, flee player, freeze). Sits between the maze wall-lookup block, which supplies per-direction passability at the ghost's current position, and the sprite renderer, which consumes `m_x`/`m_y`. One instance per ghost. The `index` input is replaced by per-instance start parameters.

## Interface
- `COORD_W`, 9, coordinate width in bits for `p_x`/`p_y`/`m_x`/`m_y`.
- `VELOCITY`, 1, pixels moved per step; must be less than 2^(COORD_W-1).
- `START_X`, 240, reset X position.
- `START_Y`, 240, reset Y position.
- `START_DIR`, 4'b0100 (U), reset heading; one-hot.
- `LFSR_SEED`, 16'hACE1, reset LFSR value; must be nonzero.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — system clock.
- `rst` in 1 — synchronous, active-high reset.
- `move_tick` in 1 — single-cycle step strobe.
- `mode` in 2 — 00 RANDOM, 01 CHASE, 10 FLEE, 11 FREEZE.
- `pass` in 4 — {L,U,R,D} open flags at current `m_x`/`m_y`; 1 = open; valid whenever `move_tick`=1.
- `p_x`, `p_y` in COORD_W — player position.
- `m_x`, `m_y` out COORD_W — ghost position (registered).
- `dir` out 4 — current heading, one-hot {L,U,R,D} (registered).
- `stepped` out 1 — 1-cycle pulse; position changed this tick.
- `turned` out 1 — 1-cycle pulse; heading changed this tick.

## Operation
- Direction encoding: L=1000, U=0100, R=0010, D=0001. The reverse of L is R, and the reverse of U is D.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every `clk` cycle regardless of `move_tick`, which decorrelates multiple instances.
- Candidate set `C` = `pass` & ~reverse(`dir`). If `C`=0, then `C` = `pass` & reverse(`dir`) (dead end: reverse). If `C` is still 0, there is no move.
- Heading choice on a tick, per mode:
  - RANDOM: keep `dir` if `pass[dir]`; otherwise pick from `C`. With one member, take it. With two, `lfsr[0]` selects (0 = higher-order bit). With three, `lfsr[1:0]`: 0/1/2 select by bit order, 3 selects the first.
  - CHASE: `dx` = |p_x−m_x|, `dy` = |p_y−m_y|, both unsigned compare-then-subtract with no signed wrap. Horizontal preference is R if p_x>m_x, L if p_x<m_x, none if equal; vertical likewise (D if p_y>m_y). The primary axis is the one with larger delta; ties go to horizontal. Take the first preferred direction in `C` (primary, then secondary). Else keep `dir` if in `C`; else take the highest-order bit of `C`. Re-evaluated on every tick, so the ghost turns at junctions.
  - FLEE: same as CHASE with preferences inverted; equal coordinates give no preference on that axis.
  - FREEZE: no heading change, no move, no pulses.
- Move: on the same tick, step `VELOCITY` in the chosen heading. The step is taken only if that heading's `pass` bit is 1. Arithmetic is modulo 2^COORD_W (tunnel wrap).
- `turned`=1 iff the chosen heading ≠ previous `dir`. `stepped`=1 iff a move occurred.

## Timing
- Reset values: `m_x`=START_X, `m_y`=START_Y, `dir`=START_DIR, `stepped`=0, `turned`=0, LFSR=LFSR_SEED.
- `rst` overrides `move_tick` in the same cycle. Reset mid-operation returns to start values on the next edge.
- Latency is 1 cycle: `pass`, `p_x`/`p_y` and `mode` are sampled at the edge where `move_tick`=1. Outputs reflect the result after that edge.
- Pulses are high for exactly the cycle after the tick edge.
- Without `move_tick`, all outputs hold except that pulses clear.
- A `mode` change takes effect on the next tick. Back-to-back ticks (every cycle) are legal.

## Structure
- Package `ghost_pkg`:
  - direction constants L/U/R/D;
  - mode encoding;
  - `reverse_dir` function;
  - LFSR tap constant.
- Sub-module `ghost_lfsr` (16-bit, seed parameter, synchronous reset, free-running).
- Heading selection is combinational in `ghost_mover`. Position, heading and pulse registers live in `ghost_mover`.

## Test plan
- Reset: with `rst`=1 and `move_tick`=1, outputs are m=(240,240), dir=U, no pulses. After release, a tick with pass=0100 gives m_y=239 and stepped=1.
- RANDOM wall hit: dir=U, pass=1010, LFSR forced so `lfsr[0]`=0 → dir=L, m_x=239, turned=1. With `lfsr[0]`=1 → dir=R, m_x=241.
- Dead end: dir=R, pass=1000 → dir=L, m_x−1. With pass=0000 → stepped=0 and turned=0; position is unchanged.
- CHASE: m=(100,100), p=(150,110), dir=U, pass=1111 → dir=R, m_x=101. With p=(90,200) and pass=1111 → dir=D.
- FLEE tie/equal: m=(100,100), p=(100,80), dir=L, pass=1111 → dir=D. FREEZE over 5 ticks: outputs are constant.
- Wrap: COORD_W=9, m_x=0, dir=L, pass=1000 → m_x=511. With m_x=511, dir=R → m_x=0.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost movement controller:
// heading encoding, mode encoding and LFSR taps.
package ghost_pkg;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_FLEE   = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  // taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] reverse_dir(
    input logic [3:0] d
  );
    return {d[1:0], d[3:2]};
  endfunction

endpackage

// File: rtl/ghost_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the
// ghost's random source.
import ghost_pkg::*;

module ghost_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/ghost_mover.sv
// One ghost: position/heading registers plus the
// per-tick heading choice for each movement mode.
import ghost_pkg::*;

module ghost_mover #(
  parameter int          COORD_W   = 9,
  parameter int          VELOCITY  = 1,
  parameter int          START_X   = 240,
  parameter int          START_Y   = 240,
  parameter logic [3:0]  START_DIR = 4'b0100,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_tick,
  input  logic [1:0]         mode,
  input  logic [3:0]         pass,
  input  logic [COORD_W-1:0] p_x,
  input  logic [COORD_W-1:0] p_y,
  output logic [COORD_W-1:0] m_x,
  output logic [COORD_W-1:0] m_y,
  output logic [3:0]         dir,
  output logic               stepped,
  output logic               turned
);

  localparam logic [COORD_W-1:0] VEL =
    COORD_W'(VELOCITY);

  logic [15:0] lfsr;
  logic        unused_lfsr;

  ghost_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:2];

  mode_e              mode_q;
  logic [3:0]         rev, cand_f, cand;
  logic [3:0]         c_hi, c_lo, c_mid;
  logic [2:0]         n_cand;
  logic [3:0]         rnd, seek, pick;
  logic [3:0]         h_pref, v_pref;
  logic [3:0]         pri, sec;
  logic [COORD_W-1:0] dx, dy, nx, ny;
  logic               active, go;

  assign mode_q = mode_e'(mode);
  assign rev    = reverse_dir(dir);
  assign cand_f = pass & ~rev;
  // dead end: fall back to reversing
  assign cand   = (|cand_f) ? cand_f : (pass & rev);
  assign n_cand = 3'($countones(cand));

  always_comb begin
    c_hi = '0;
    c_lo = '0;
    for (int i = 0; i < 4; i++)
      if (cand[i]) c_hi = 4'b0001 << i;
    for (int i = 3; i >= 0; i--)
      if (cand[i]) c_lo = 4'b0001 << i;
  end

  assign c_mid = cand & ~c_hi & ~c_lo;

  always_comb begin
    rnd = dir;
    if (!(|(pass & dir))) begin
      case (n_cand)
        3'd1: rnd = c_hi;
        3'd2: rnd = lfsr[0] ? c_lo : c_hi;
        3'd3: begin
          case (lfsr[1:0])
            2'd1:    rnd = c_mid;
            2'd2:    rnd = c_lo;
            default: rnd = c_hi;
          endcase
        end
        default: rnd = dir;
      endcase
    end
  end

  assign dx = (p_x > m_x) ? p_x - m_x : m_x - p_x;
  assign dy = (p_y > m_y) ? p_y - m_y : m_y - p_y;

  always_comb begin
    h_pref = '0;
    v_pref = '0;
    if (p_x > m_x)      h_pref = DIR_R;
    else if (p_x < m_x) h_pref = DIR_L;
    if (p_y > m_y)      v_pref = DIR_D;
    else if (p_y < m_y) v_pref = DIR_U;
    // fleeing wants the opposite of chasing
    if (mode_q == MODE_FLEE) begin
      h_pref = reverse_dir(h_pref);
      v_pref = reverse_dir(v_pref);
    end
    pri = (dx >= dy) ? h_pref : v_pref;
    sec = (dx >= dy) ? v_pref : h_pref;
    if (|(pri & cand))      seek = pri;
    else if (|(sec & cand)) seek = sec;
    else if (|(dir & cand)) seek = dir;
    else if (|cand)         seek = c_hi;
    else                    seek = dir;
  end

  always_comb begin
    pick   = dir;
    active = 1'b0;
    if (move_tick) begin
      unique case (mode_q)
        MODE_RANDOM: begin
          pick   = rnd;
          active = 1'b1;
        end
        MODE_CHASE, MODE_FLEE: begin
          pick   = seek;
          active = 1'b1;
        end
        MODE_FREEZE: ;
      endcase
    end
  end

  assign go = active && (|(pick & pass));

  always_comb begin
    nx = m_x;
    ny = m_y;
    if (go) begin
      unique case (1'b1)
        pick[3]: nx = m_x - VEL;
        pick[2]: ny = m_y - VEL;
        pick[1]: nx = m_x + VEL;
        pick[0]: ny = m_y + VEL;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_x     <= COORD_W'(START_X);
      m_y     <= COORD_W'(START_Y);
      dir     <= START_DIR;
      stepped <= 1'b0;
      turned  <= 1'b0;
    end else begin
      m_x     <= nx;
      m_y     <= ny;
      dir     <= pick;
      stepped <= go;
      turned  <= active && (pick != dir);
    end
  end

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover with a scoreboard of
// expected outputs fed by a behavioural model.
module tb_ghost_mover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_tick = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] pass = 4'b0000;
  logic [8:0] p_x = '0;
  logic [8:0] p_y = '0;
  logic [8:0] m_x, m_y;
  logic [3:0] dir;
  logic       stepped, turned;

  int n_total = 0;
  int n_pass  = 0;

  logic [8:0]  mx_m, my_m;
  logic [3:0]  dir_m;
  logic [15:0] lfsr_m;
  logic [23:0] sb[$];

  ghost_mover #(
    .COORD_W   (9),
    .VELOCITY  (1),
    .START_X   (240),
    .START_Y   (240),
    .START_DIR (4'b0100),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .move_tick (move_tick),
    .mode      (mode),
    .pass      (pass),
    .p_x       (p_x),
    .p_y       (p_y),
    .m_x       (m_x),
    .m_y       (m_y),
    .dir       (dir),
    .stepped   (stepped),
    .turned    (turned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else lfsr_m <= {lfsr_m[14:0],
      lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d",
                tag, got, exp);
  endtask

  task automatic step(input logic r, input logic t,
                      input logic [1:0] md,
                      input logic [3:0] ps,
                      input logic [8:0] px,
                      input logic [8:0] py);
    logic [3:0]  rv, c, nd, hp, vp;
    logic [3:0]  mem [4];
    logic [3:0]  order [3];
    logic [23:0] e, got;
    logic        st, tu;
    int          n, ix, iy, jx, jy, ddx, ddy;
    @(negedge clk);
    rst = r; move_tick = t; mode = md;
    pass = ps; p_x = px; p_y = py;
    st = 1'b0; tu = 1'b0;
    if (r) begin
      mx_m = 9'd240; my_m = 9'd240; dir_m = 4'b0100;
    end else if (t && md != 2'b11) begin
      rv = {dir_m[1], dir_m[0], dir_m[3], dir_m[2]};
      c = ps & ~rv;
      if (c == 4'b0) c = ps & rv;
      n = 0;
      for (int b = 3; b >= 0; b--)
        if (c[b]) begin
          mem[n] = 4'b0; mem[n][b] = 1'b1; n++;
        end
      if (md == 2'b00) begin
        if ((ps & dir_m) != 4'b0) nd = dir_m;
        else if (n == 0) nd = dir_m;
        else if (n == 1) nd = mem[0];
        else if (n == 2) nd = mem[int'(lfsr_m[0])];
        else if (lfsr_m[1:0] == 2'd3) nd = mem[0];
        else nd = mem[int'(lfsr_m[1:0])];
      end else begin
        ix = int'(mx_m); iy = int'(my_m);
        jx = int'(px);   jy = int'(py);
        ddx = (ix > jx) ? ix - jx : jx - ix;
        ddy = (iy > jy) ? iy - jy : jy - iy;
        if (md == 2'b01) begin
          hp = (jx > ix) ? 4'b0010 : (jx < ix) ? 4'b1000 : 4'b0;
          vp = (jy > iy) ? 4'b0001 : (jy < iy) ? 4'b0100 : 4'b0;
        end else begin
          hp = (jx > ix) ? 4'b1000 : (jx < ix) ? 4'b0010 : 4'b0;
          vp = (jy > iy) ? 4'b0100 : (jy < iy) ? 4'b0001 : 4'b0;
        end
        order[0] = (ddx >= ddy) ? hp : vp;
        order[1] = (ddx >= ddy) ? vp : hp;
        order[2] = dir_m;
        nd = 4'b0;
        for (int k = 0; k < 3; k++)
          if (nd == 4'b0 && (order[k] & c) != 4'b0)
            nd = order[k];
        if (nd == 4'b0) nd = (n > 0) ? mem[0] : dir_m;
      end
      st = (nd & ps) != 4'b0;
      tu = nd != dir_m;
      if (st) begin
        if (nd == 4'b1000) mx_m = mx_m - 9'd1;
        if (nd == 4'b0010) mx_m = mx_m + 9'd1;
        if (nd == 4'b0100) my_m = my_m - 9'd1;
        if (nd == 4'b0001) my_m = my_m + 9'd1;
      end
      dir_m = nd;
    end
    sb.push_back({mx_m, my_m, dir_m, st, tu});
    @(posedge clk);
    #1;
    got = {m_x, m_y, dir, stepped, turned};
    e = sb.pop_front();
    n_total++;
    assert (got === e) n_pass++;
    else $error("FAIL scoreboard: got m=(%0d,%0d) dir=%b st=%b tu=%b expected m=(%0d,%0d) dir=%b st=%b tu=%b",
                got[23:15], got[14:6], got[5:2], got[1], got[0],
                e[23:15], e[14:6], e[5:2], e[1], e[0]);
  endtask

  task automatic wait_lfsr0(input logic want);
    for (int k = 0; k < 64 && lfsr_m[0] !== want; k++)
      step(1'b0, 1'b0, 2'b00, 4'b0, 9'd0, 9'd0);
    check("lfsr_wait", {31'b0, lfsr_m[0]}, {31'b0, want});
  endtask

  initial begin
    step(1'b1, 1'b1, 2'b00, 4'b0100, 9'd0, 9'd0);
    check("rst_mx", m_x, 240);
    check("rst_my", m_y, 240);
    check("rst_dir", dir, 4'b0100);
    check("rst_pulses", {stepped, turned}, 0);

    step(1'b0, 1'b1, 2'b00, 4'b0100, 9'd0, 9'd0);
    check("first_my", m_y, 239);
    check("first_stepped", stepped, 1);

    wait_lfsr0(1'b0);
    step(1'b0, 1'b1, 2'b00, 4'b1010, 9'd0, 9'd0);
    check("rnd0_dir", dir, 4'b1000);
    check("rnd0_mx", m_x, 239);
    check("rnd0_turned", turned, 1);

    step(1'b0, 1'b1, 2'b00, 4'b0100, 9'd0, 9'd0);
    wait_lfsr0(1'b1);
    step(1'b0, 1'b1, 2'b00, 4'b1010, 9'd0, 9'd0);
    check("rnd1_dir", dir, 4'b0010);
    check("rnd1_mx", m_x, 240);

    step(1'b0, 1'b1, 2'b00, 4'b1000, 9'd0, 9'd0);
    check("dead_dir", dir, 4'b1000);
    check("dead_mx", m_x, 239);
    step(1'b0, 1'b1, 2'b00, 4'b0000, 9'd0, 9'd0);
    check("closed_pulses", {stepped, turned}, 0);
    check("closed_mx", m_x, 239);

    for (int k = 0; k < 300 && my_m != 9'd101; k++)
      step(1'b0, 1'b1, 2'b00, 4'b0100, 9'd0, 9'd0);
    for (int k = 0; k < 300 && mx_m != 9'd100; k++)
      step(1'b0, 1'b1, 2'b00, 4'b1000, 9'd0, 9'd0);
    step(1'b0, 1'b1, 2'b00, 4'b0100, 9'd0, 9'd0);
    check("walk_pos", {m_x, m_y}, {9'd100, 9'd100});
    check("walk_dir", dir, 4'b0100);

    step(1'b0, 1'b1, 2'b01, 4'b1111, 9'd150, 9'd110);
    check("chase1_dir", dir, 4'b0010);
    check("chase1_mx", m_x, 101);
    step(1'b0, 1'b1, 2'b01, 4'b1111, 9'd90, 9'd200);
    check("chase2_dir", dir, 4'b0001);

    step(1'b0, 1'b1, 2'b00, 4'b1000, 9'd0, 9'd0);
    step(1'b0, 1'b1, 2'b10, 4'b1111, 9'd100, 9'd81);
    check("flee_dir", dir, 4'b0001);
    check("flee_my", m_y, 102);

    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 2'b11, 4'b1111, 9'd7, 9'd9);
      check("freeze", {m_x, m_y, dir, stepped, turned},
            {9'd100, 9'd102, 4'b0001, 2'b00});
    end

    for (int k = 0; k < 300 && mx_m != 9'd0; k++)
      step(1'b0, 1'b1, 2'b00, 4'b1000, 9'd0, 9'd0);
    check("wrap_at0", m_x, 0);
    step(1'b0, 1'b1, 2'b00, 4'b1000, 9'd0, 9'd0);
    check("wrap_511", m_x, 511);
    step(1'b0, 1'b1, 2'b00, 4'b0010, 9'd0, 9'd0);
    check("wrap_back_mx", m_x, 0);
    check("wrap_back_dir", dir, 4'b0010);
    check("wrap_back_turn", turned, 1);

    step(1'b0, 1'b0, 2'b00, 4'b1111, 9'd0, 9'd0);
    check("idle_pulses", {stepped, turned}, 0);
    check("idle_hold", m_x, 0);

    step(1'b1, 1'b1, 2'b00, 4'b1111, 9'd0, 9'd0);
    check("rst2_pos", {m_x, m_y}, {9'd240, 9'd240});
    check("rst2_dir", dir, 4'b0100);
    check("rst2_pulses", {stepped, turned}, 0);
    step(1'b0, 1'b1, 2'b00, 4'b0100, 9'd0, 9'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
